// File: rtl/dual_fetch_queue.sv
// dual_fetch_queue: dual-issue fetch stage feeding a small circular queue of {pc, instr} entries.
// Optional macro FETCH_BYPASS_EN forwards a response straight to the slots when the queue is empty.
module dual_fetch_queue #(
  parameter int          QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [63:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [1:0]  deq_cnt,
  output logic [31:0] PCF1,
  output logic [31:0] PCF2,
  output logic [31:0] PCPlus4F1,
  output logic [31:0] PCPlus4F2,
  output logic [31:0] InstrF1,
  output logic [31:0] InstrF2,
  output logic        validF1,
  output logic        validF2
);

  localparam int          AW      = $clog2(QDEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(QDEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   fpc_r;
  logic          run_r;
  logic          infl_r;
  logic          infl_hi_r;
  logic [31:0]   infl_addr_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [31:0]   q_pc_r    [QDEPTH];
  logic [31:0]   q_instr_r [QDEPTH];

  logic          resp_v_s;
  logic          byp_s;
  logic [CW-1:0] resp_n_s;
  logic [CW-1:0] deq_req_s;
  logic [CW-1:0] avail_s;
  logic [CW-1:0] deq_eff_s;
  logic [CW-1:0] skip_s;
  logic [CW-1:0] deq_q_s;
  logic [CW-1:0] enq_n_s;
  logic [CW:0]   have_s;
  logic [CW:0]   need_s;
  logic [31:0]   e0_pc_s;
  logic [31:0]   e0_instr_s;
  logic [31:0]   e1_pc_s;
  logic [31:0]   e1_instr_s;
  logic          wr0_en_s;
  logic          wr1_en_s;
  logic [31:0]   wr0_pc_s;
  logic [31:0]   wr0_instr_s;
  logic [AW-1:0] head1_s;
  logic          s1_v_s;
  logic          s2_v_s;
  logic [31:0]   s1_pc_s;
  logic [31:0]   s2_pc_s;
  logic [31:0]   s1_instr_s;
  logic [31:0]   s2_instr_s;

  // Response decode, dequeue accounting and issue decision.
  always_comb begin
    resp_v_s   = infl_r & ~redirect;
    e1_pc_s    = infl_addr_r + 32'd4;
    e1_instr_s = imem_rdata[63:32];
    if (!infl_r) begin
      resp_n_s = CW'(0);
    end else if (infl_hi_r) begin
      resp_n_s = CW'(1);
    end else begin
      resp_n_s = CW'(2);
    end
    // An upper-word-only fetch makes the upper word the first entry.
    if (infl_hi_r) begin
      e0_pc_s    = e1_pc_s;
      e0_instr_s = e1_instr_s;
    end else begin
      e0_pc_s    = infl_addr_r;
      e0_instr_s = imem_rdata[31:0];
    end
`ifdef FETCH_BYPASS_EN
    byp_s = resp_v_s && (count_r == CW'(0));
`else
    byp_s = 1'b0;
`endif
    deq_req_s = (deq_cnt == 2'd3) ? CW'(2) : CW'(deq_cnt);
    avail_s   = byp_s ? resp_n_s : count_r;
    if (redirect) begin
      deq_eff_s = CW'(0);
    end else if (deq_req_s > avail_s) begin
      deq_eff_s = avail_s;
    end else begin
      deq_eff_s = deq_req_s;
    end
    // Bypassed entries consumed this cycle never enter storage.
    skip_s   = byp_s ? deq_eff_s : CW'(0);
    deq_q_s  = byp_s ? CW'(0) : deq_eff_s;
    enq_n_s  = resp_v_s ? (resp_n_s - skip_s) : CW'(0);
    wr0_en_s = (enq_n_s >= CW'(1));
    wr1_en_s = (enq_n_s == CW'(2));
    if (skip_s == CW'(0)) begin
      wr0_pc_s    = e0_pc_s;
      wr0_instr_s = e0_instr_s;
    end else begin
      wr0_pc_s    = e1_pc_s;
      wr0_instr_s = e1_instr_s;
    end
    have_s    = DEPTH_W + {1'b0, deq_eff_s};
    need_s    = {1'b0, count_r} + {1'b0, resp_n_s} + (CW + 1)'(2);
    imem_req  = run_r & ~redirect & (have_s >= need_s);
    imem_addr = fpc_r & 32'hFFFF_FFF8;
  end

  // Fetch PC, in-flight tracking and queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_r       <= RESET_PC;
      run_r       <= 1'b0;
      infl_r      <= 1'b0;
      infl_hi_r   <= 1'b0;
      infl_addr_r <= 32'h0;
      head_r      <= AW'(0);
      tail_r      <= AW'(0);
      count_r     <= CW'(0);
    end else begin
      run_r       <= 1'b1;
      infl_r      <= imem_req;
      infl_hi_r   <= fpc_r[2];
      infl_addr_r <= imem_addr;
      if (redirect) begin
        fpc_r   <= redirect_pc & 32'hFFFF_FFFC;
        head_r  <= AW'(0);
        tail_r  <= AW'(0);
        count_r <= CW'(0);
      end else begin
        if (imem_req) begin
          fpc_r <= imem_addr + 32'd8;
        end
        head_r  <= head_r + deq_q_s[AW-1:0];
        tail_r  <= tail_r + enq_n_s[AW-1:0];
        count_r <= count_r + enq_n_s - deq_q_s;
      end
    end
  end

  // Queue storage, written in PC order starting at tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_r[i]    <= 32'h0;
        q_instr_r[i] <= NOP;
      end
    end else begin
      if (wr0_en_s) begin
        q_pc_r[tail_r]    <= wr0_pc_s;
        q_instr_r[tail_r] <= wr0_instr_s;
      end
      if (wr1_en_s) begin
        q_pc_r[tail_r + AW'(1)]    <= e1_pc_s;
        q_instr_r[tail_r + AW'(1)] <= e1_instr_s;
      end
    end
  end

  // Slot outputs from queue head, or from the live response when bypassing.
  always_comb begin
    head1_s = head_r + AW'(1);
    if (byp_s) begin
      s1_v_s     = 1'b1;
      s1_pc_s    = e0_pc_s;
      s1_instr_s = e0_instr_s;
      s2_v_s     = (resp_n_s == CW'(2));
      s2_pc_s    = e1_pc_s;
      s2_instr_s = e1_instr_s;
    end else begin
      s1_v_s     = (count_r >= CW'(1));
      s1_pc_s    = q_pc_r[head_r];
      s1_instr_s = q_instr_r[head_r];
      s2_v_s     = (count_r >= CW'(2));
      s2_pc_s    = q_pc_r[head1_s];
      s2_instr_s = q_instr_r[head1_s];
    end
    validF1   = s1_v_s;
    PCF1      = s1_v_s ? s1_pc_s : 32'h0;
    PCPlus4F1 = s1_v_s ? (s1_pc_s + 32'd4) : 32'h0;
    InstrF1   = s1_v_s ? s1_instr_s : NOP;
    validF2   = s2_v_s;
    PCF2      = s2_v_s ? s2_pc_s : 32'h0;
    PCPlus4F2 = s2_v_s ? (s2_pc_s + 32'd4) : 32'h0;
    InstrF2   = s2_v_s ? s2_instr_s : NOP;
  end

endmodule
